rvx_bus_arbiter: RTL and testbench
==================================

Name: rvx_bus_arbiter

Overview:
- Parametrised successor to the single-manager system bus.
- Connects NUM_MANAGERS managers (e.g. core plus DMA or debug) to NUM_DEVICES memory-mapped devices.
- Grants one transaction at a time using round-robin arbitration and registered address decode.
- Returns an access fault for unmapped addresses and, optionally, for devices that never respond.

Parameters:
- NUM_MANAGERS, 2, number of manager ports (1..8).
- NUM_DEVICES, 5, number of managed device ports (1..16).
- TIMEOUT_CYCLES, 255, device-response wait limit; used only with RVX_BUS_TIMEOUT_EN (1..65535).

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- manager_rw_address  in  NUM_MANAGERS*32  per-manager byte address.
- manager_read_request  in  NUM_MANAGERS  level; held until the matching response.
- manager_write_request  in  NUM_MANAGERS  level; held until the matching response.
- manager_write_data  in  NUM_MANAGERS*32  write data.
- manager_write_strobe  in  NUM_MANAGERS*4  byte enables.
- manager_read_data  out  NUM_MANAGERS*32  read data; valid with read_response.
- manager_read_response  out  NUM_MANAGERS  one-cycle pulse.
- manager_write_response  out  NUM_MANAGERS  one-cycle pulse.
- manager_access_fault  out  NUM_MANAGERS  one-cycle pulse, coincident with a response.
- device_rw_address  out  32  latched address of the granted transaction.
- device_write_data  out  32  latched write data.
- device_write_strobe  out  4  latched byte enables.
- device_read_request  out  NUM_DEVICES  one-hot or zero.
- device_write_request  out  NUM_DEVICES  one-hot or zero.
- device_read_data  in  NUM_DEVICES*32  per-device read data.
- device_read_response  in  NUM_DEVICES  one-cycle pulse.
- device_write_response  in  NUM_DEVICES  one-cycle pulse.
- device_start_address  in  NUM_DEVICES*32  region base addresses.
- device_region_size  in  NUM_DEVICES*32  region sizes; each a power of two, base aligned to it.
- bus_busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: all outputs 0; state=IDLE; round-robin pointer=0; latched address, data and strobe=0.
- States and transitions:
  - IDLE: if any request is pending, pick the first requesting manager at or after the pointer (wrapping). Latch its address, data, strobe and op; write wins if read and write are both high. Set pointer=grant+1 mod NUM_MANAGERS. Go to DECODE.
  - DECODE (1 cycle): match device d when (addr & ~(size-1)) == start; the lowest index wins on overlap. Hit: go to ACCESS. Miss: go to RESP with fault=1 and rdata=0.
  - ACCESS: hold device_{read|write}_request[d] high. On device response pulse, capture rdata (reads only), go to RESP. Responses from non-selected devices are ignored.
  - RESP (1 cycle): pulse manager_{read|write}_response[grant]; drive manager_read_data[grant]; pulse manager_access_fault[grant] if fault. Go to IDLE.
- Minimum latency, request to response: 4 cycles (IDLE, DECODE, ACCESS with same-cycle device response, RESP).
- In the IDLE cycle directly after RESP, the just-served manager's request is masked; managers drop request the cycle after response.
- Manager read_data for non-granted managers = 0.
- Request deasserted mid-transaction: ignored; the transaction completes and the response is still pulsed.
- NUM_MANAGERS=1: pointer is constant 0; behaviour is otherwise identical.
- Reset mid-ACCESS: device request drops next cycle; no response is issued.

Optional Feature:
- Macro: RVX_BUS_TIMEOUT_EN.
- Defined: a 16-bit counter clears on entry to ACCESS and increments each ACCESS cycle. When it reaches TIMEOUT_CYCLES, drop the device request and go to RESP with fault=1 and rdata=0. A device response arriving in that same cycle wins: normal response, no fault.
- Undefined: no counter; ACCESS waits indefinitely; fault is raised only for decode miss.

Decomposition:
- Package rvx_bus_pkg: state encoding (IDLE, DECODE, ACCESS, RESP), op encoding, and the address-match function.
- Sub-module rvx_bus_rr_arbiter: request vector plus pointer in; one-hot grant, grant index and valid out; combinational.

Test Plan:
- M0 reads 0x0000_0010, RAM responds 1 cycle after request -> M0 read_response pulse at cycle 5 with RAM data 0xDEADBEEF; no fault.
- M0 and M1 request continuously, pointer=0 -> grants alternate M0,M1,M0,M1 over 4 transactions.
- M1 writes 0x9000_0000 (unmapped) -> write_response and access_fault pulse together on M1; no device request is ever asserted.
- Simultaneous read+write from M0 to 0x8002_0004 -> only device_write_request[3] is asserted.
- With RVX_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=8, device 2 is mute -> request held 8 cycles, then read_response + fault with data 0; repeat with a response at cycle 8 -> no fault.
- Reset asserted during ACCESS -> all outputs 0 the next cycle; the following request is served normally with the pointer at 0.

Source files
------------

// File: rtl/rvx_bus_pkg.sv
// rvx_bus_pkg: shared types and helpers for the rvx multi-manager system bus.
// Optional feature macro used by the bus: RVX_BUS_TIMEOUT_EN.
package rvx_bus_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } bus_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } bus_op_t;

  // Region match for a power-of-two sized, size-aligned device window.
  function automatic logic addr_match(input logic [WORD_W-1:0] addr,
                                      input logic [WORD_W-1:0] start,
                                      input logic [WORD_W-1:0] size);
    return (addr & ~(size - 32'd1)) == start;
  endfunction

endpackage

// File: rtl/rvx_bus_rr_arbiter.sv
// rvx_bus_rr_arbiter: combinational round-robin pick, first requester at or
// after the pointer, wrapping around the manager set.
module rvx_bus_rr_arbiter #(
  parameter int unsigned NUM_MANAGERS = 2,
  parameter int unsigned PTR_W        = (NUM_MANAGERS > 1) ? $clog2(NUM_MANAGERS) : 1
) (
  input  logic [NUM_MANAGERS-1:0] request,
  input  logic [PTR_W-1:0]        pointer,
  output logic [NUM_MANAGERS-1:0] grant,
  output logic [PTR_W-1:0]        grant_index,
  output logic                    grant_valid
);

  // Scan from the pointer position and keep the first requester found.
  always_comb begin
    logic [31:0] idx;
    idx         = '0;
    grant       = '0;
    grant_index = '0;
    grant_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_MANAGERS; i++) begin
      idx = (32'(pointer) + i) % NUM_MANAGERS;
      if (!grant_valid && request[idx[PTR_W-1:0]]) begin
        grant[idx[PTR_W-1:0]] = 1'b1;
        grant_index           = idx[PTR_W-1:0];
        grant_valid           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rvx_bus_arbiter.sv
// rvx_bus_arbiter: NUM_MANAGERS to NUM_DEVICES system bus, one transaction at
// a time, round-robin grant, registered address decode, access fault on
// unmapped addresses. Define RVX_BUS_TIMEOUT_EN to also fault devices that do
// not answer within TIMEOUT_CYCLES access cycles.
module rvx_bus_arbiter
  import rvx_bus_pkg::*;
#(
  parameter int unsigned NUM_MANAGERS   = 2,
  parameter int unsigned NUM_DEVICES    = 5,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_MANAGERS*32-1:0] manager_rw_address,
  input  logic [NUM_MANAGERS-1:0]    manager_read_request,
  input  logic [NUM_MANAGERS-1:0]    manager_write_request,
  input  logic [NUM_MANAGERS*32-1:0] manager_write_data,
  input  logic [NUM_MANAGERS*4-1:0]  manager_write_strobe,
  output logic [NUM_MANAGERS*32-1:0] manager_read_data,
  output logic [NUM_MANAGERS-1:0]    manager_read_response,
  output logic [NUM_MANAGERS-1:0]    manager_write_response,
  output logic [NUM_MANAGERS-1:0]    manager_access_fault,
  output logic [31:0]                device_rw_address,
  output logic [31:0]                device_write_data,
  output logic [3:0]                 device_write_strobe,
  output logic [NUM_DEVICES-1:0]     device_read_request,
  output logic [NUM_DEVICES-1:0]     device_write_request,
  input  logic [NUM_DEVICES*32-1:0]  device_read_data,
  input  logic [NUM_DEVICES-1:0]     device_read_response,
  input  logic [NUM_DEVICES-1:0]     device_write_response,
  input  logic [NUM_DEVICES*32-1:0]  device_start_address,
  input  logic [NUM_DEVICES*32-1:0]  device_region_size,
  output logic                       bus_busy
);

  localparam int unsigned MGR_W = (NUM_MANAGERS > 1) ? $clog2(NUM_MANAGERS) : 1;
  localparam int unsigned DEV_W = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1;

  bus_state_t              state;
  bus_op_t                 op;
  logic [MGR_W-1:0]        pointer;
  logic [MGR_W-1:0]        grant_idx;
  logic [NUM_MANAGERS-1:0] grant_oh;
  logic [NUM_MANAGERS-1:0] served_mask;
  logic [DEV_W-1:0]        dev_sel;

  logic [NUM_MANAGERS-1:0] pending;
  logic [NUM_MANAGERS-1:0] arb_grant;
  logic [MGR_W-1:0]        arb_idx;
  logic                    arb_valid;
  logic [MGR_W-1:0]        ptr_next;

  logic                    dec_hit;
  logic [DEV_W-1:0]        dec_idx;

  logic                    sel_resp;
  logic [31:0]             sel_rdata;
  logic                    timeout_hit;

  logic                    resp_fire;
  logic                    resp_fault;
  logic [31:0]             resp_data;

  // The manager served last is held off for exactly one IDLE cycle.
  assign pending  = (manager_read_request | manager_write_request) & ~served_mask;
  assign ptr_next = (arb_idx == MGR_W'(NUM_MANAGERS - 1)) ? '0 : arb_idx + 1'b1;
  assign bus_busy = (state != IDLE);

  rvx_bus_rr_arbiter #(
    .NUM_MANAGERS(NUM_MANAGERS),
    .PTR_W       (MGR_W)
  ) u_rr_arbiter (
    .request    (pending),
    .pointer    (pointer),
    .grant      (arb_grant),
    .grant_index(arb_idx),
    .grant_valid(arb_valid)
  );

  // Address decode of the latched address; lowest device index wins overlaps.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int unsigned d = 0; d < NUM_DEVICES; d++) begin
      if (!dec_hit && addr_match(device_rw_address,
                                 device_start_address[d*32 +: 32],
                                 device_region_size[d*32 +: 32])) begin
        dec_hit = 1'b1;
        dec_idx = DEV_W'(d);
      end
    end
  end

  // Only the selected device's response and data are observed.
  always_comb begin
    sel_resp  = (op == OP_WRITE) ? device_write_response[dev_sel]
                                 : device_read_response[dev_sel];
    sel_rdata = device_read_data[dev_sel*32 +: 32];
  end

`ifdef RVX_BUS_TIMEOUT_EN
  logic [15:0] wait_count;

  // Counts ACCESS cycles; parked at zero elsewhere so each access starts fresh.
  always_ff @(posedge clock) begin
    if (reset || state != ACCESS) wait_count <= '0;
    else                          wait_count <= wait_count + 16'd1;
  end

  assign timeout_hit = (state == ACCESS) && ((wait_count + 16'd1) == 16'(TIMEOUT_CYCLES));
`else
  logic unused_timeout;
  assign timeout_hit    = 1'b0;
  assign unused_timeout = ^16'(TIMEOUT_CYCLES);
`endif

  // Decide whether this cycle ends the transaction, and with what outcome.
  // A device response in the timeout cycle takes priority over the fault.
  always_comb begin
    resp_fire  = 1'b0;
    resp_fault = 1'b0;
    resp_data  = '0;
    if (state == DECODE && !dec_hit) begin
      resp_fire  = 1'b1;
      resp_fault = 1'b1;
    end else if (state == ACCESS && sel_resp) begin
      resp_fire = 1'b1;
      resp_data = (op == OP_READ) ? sel_rdata : '0;
    end else if (state == ACCESS && timeout_hit) begin
      resp_fire  = 1'b1;
      resp_fault = 1'b1;
    end
  end

  // Transaction FSM with registered device requests and manager responses.
  always_ff @(posedge clock) begin
    if (reset) begin
      state                  <= IDLE;
      op                     <= OP_READ;
      pointer                <= '0;
      grant_idx              <= '0;
      grant_oh               <= '0;
      served_mask            <= '0;
      dev_sel                <= '0;
      device_rw_address      <= '0;
      device_write_data      <= '0;
      device_write_strobe    <= '0;
      device_read_request    <= '0;
      device_write_request   <= '0;
      manager_read_response  <= '0;
      manager_write_response <= '0;
      manager_access_fault   <= '0;
      manager_read_data      <= '0;
    end else begin
      manager_read_response  <= '0;
      manager_write_response <= '0;
      manager_access_fault   <= '0;
      manager_read_data      <= '0;
      case (state)
        IDLE: begin
          served_mask <= '0;
          if (arb_valid) begin
            grant_idx           <= arb_idx;
            grant_oh            <= arb_grant;
            pointer             <= ptr_next;
            op                  <= manager_write_request[arb_idx] ? OP_WRITE : OP_READ;
            device_rw_address   <= manager_rw_address[arb_idx*32 +: 32];
            device_write_data   <= manager_write_data[arb_idx*32 +: 32];
            device_write_strobe <= manager_write_strobe[arb_idx*4 +: 4];
            state               <= DECODE;
          end
        end
        DECODE: begin
          if (dec_hit) begin
            dev_sel <= dec_idx;
            if (op == OP_WRITE) device_write_request[dec_idx] <= 1'b1;
            else                device_read_request[dec_idx]  <= 1'b1;
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (resp_fire) begin
            device_read_request  <= '0;
            device_write_request <= '0;
          end
        end
        RESP: begin
          served_mask <= grant_oh;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (resp_fire) begin
        if (op == OP_WRITE) manager_write_response[grant_idx] <= 1'b1;
        else                manager_read_response[grant_idx]  <= 1'b1;
        manager_access_fault[grant_idx]       <= resp_fault;
        manager_read_data[grant_idx*32 +: 32] <= resp_data;
        state                                 <= RESP;
      end
    end
  end

endmodule

// File: tb/tb_rvx_bus_arbiter.sv
// tb_rvx_bus_arbiter: directed self-checking bench for rvx_bus_arbiter.
// Timeout vectors are included when RVX_BUS_TIMEOUT_EN is defined.
module tb_rvx_bus_arbiter;

  localparam int NM = 2;
  localparam int ND = 5;
`ifdef RVX_BUS_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif

  logic           clock = 1'b0;
  logic           reset;
  logic [NM*32-1:0] manager_rw_address;
  logic [NM-1:0]    manager_read_request;
  logic [NM-1:0]    manager_write_request;
  logic [NM*32-1:0] manager_write_data;
  logic [NM*4-1:0]  manager_write_strobe;
  logic [NM*32-1:0] manager_read_data;
  logic [NM-1:0]    manager_read_response;
  logic [NM-1:0]    manager_write_response;
  logic [NM-1:0]    manager_access_fault;
  logic [31:0]      device_rw_address;
  logic [31:0]      device_write_data;
  logic [3:0]       device_write_strobe;
  logic [ND-1:0]    device_read_request;
  logic [ND-1:0]    device_write_request;
  logic [ND*32-1:0] device_read_data;
  logic [ND-1:0]    device_read_response;
  logic [ND-1:0]    device_write_response;
  logic [ND*32-1:0] device_start_address;
  logic [ND*32-1:0] device_region_size;
  logic             bus_busy;

  rvx_bus_arbiter #(
    .NUM_MANAGERS  (NM),
    .NUM_DEVICES   (ND),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .manager_rw_address    (manager_rw_address),
    .manager_read_request  (manager_read_request),
    .manager_write_request (manager_write_request),
    .manager_write_data    (manager_write_data),
    .manager_write_strobe  (manager_write_strobe),
    .manager_read_data     (manager_read_data),
    .manager_read_response (manager_read_response),
    .manager_write_response(manager_write_response),
    .manager_access_fault  (manager_access_fault),
    .device_rw_address     (device_rw_address),
    .device_write_data     (device_write_data),
    .device_write_strobe   (device_write_strobe),
    .device_read_request   (device_read_request),
    .device_write_request  (device_write_request),
    .device_read_data      (device_read_data),
    .device_read_response  (device_read_response),
    .device_write_response (device_write_response),
    .device_start_address  (device_start_address),
    .device_region_size    (device_region_size),
    .bus_busy              (bus_busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Results of the last run_txn
  int          r_cyc;
  int          r_acc;
  logic        r_rd, r_wr, r_flt;
  logic [31:0] r_rdata;
  logic [63:0] r_rdall;
  logic [ND-1:0] r_dev_rd, r_dev_wr;
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_strb;
  logic [7:0]  r_after;

  // One transaction from manager m; the device answers lat cycles after its
  // request first appears. Cycle 1 is the cycle the request is first driven.
  task automatic run_txn(input int m, input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] st, input int lat);
    int  acc;
    bit  done;
    @(negedge clock);
    r_cyc = -1; r_acc = 0; r_rd = 0; r_wr = 0; r_flt = 0; r_rdata = '0; r_rdall = '0;
    r_dev_rd = '0; r_dev_wr = '0; r_addr = '0; r_wdata = '0; r_strb = '0; r_after = '0;
    manager_rw_address[m*32 +: 32]  = a;
    manager_write_data[m*32 +: 32]  = wd;
    manager_write_strobe[m*4 +: 4]  = st;
    manager_read_request[m]         = rd;
    manager_write_request[m]        = wr;
    acc = 0;
    done = 0;
    for (int cyc = 1; cyc <= 400 && !done; cyc++) begin
      device_read_response  = '0;
      device_write_response = '0;
      if (device_read_request != '0 || device_write_request != '0) begin
        if (acc == 0) begin
          r_addr  = device_rw_address;
          r_wdata = device_write_data;
          r_strb  = device_write_strobe;
        end
        acc++;
        r_dev_rd |= device_read_request;
        r_dev_wr |= device_write_request;
        if (acc == lat + 1) begin
          device_read_response  = device_read_request;
          device_write_response = device_write_request;
        end
      end
      if (manager_read_response[m] || manager_write_response[m]) begin
        r_cyc   = cyc;
        r_rd    = manager_read_response[m];
        r_wr    = manager_write_response[m];
        r_flt   = manager_access_fault[m];
        r_rdata = manager_read_data[m*32 +: 32];
        r_rdall = manager_read_data;
        done    = 1;
        manager_read_request[m]  = 1'b0;
        manager_write_request[m] = 1'b0;
      end
      @(negedge clock);
    end
    device_read_response  = '0;
    device_write_response = '0;
    manager_read_request  = '0;
    manager_write_request = '0;
    r_acc   = acc;
    r_after = {manager_read_response, manager_write_response, manager_access_fault, bus_busy, 1'b0};
  endtask

  int s_mgr[4];
  int s_cyc[4];

  // Managers in req hold read requests to RAM continuously; device answers
  // in the same cycle. Records the first n responses.
  task automatic run_stream(input logic [NM-1:0] req, input int n);
    int cnt;
    @(negedge clock);
    for (int k = 0; k < 4; k++) begin s_mgr[k] = -1; s_cyc[k] = -1; end
    manager_rw_address    = {32'h0000_0020, 32'h0000_0010};
    manager_write_request = '0;
    manager_read_request  = req;
    cnt = 0;
    for (int cyc = 1; cyc <= 200 && cnt < n; cyc++) begin
      device_read_response = device_read_request;
      for (int i = 0; i < NM; i++) begin
        if (manager_read_response[i] && cnt < 4) begin
          s_mgr[cnt] = i;
          s_cyc[cnt] = cyc;
          cnt++;
        end
      end
      if (cnt >= n) manager_read_request = '0;
      @(negedge clock);
    end
    device_read_response = '0;
    manager_read_request = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset                 = 1'b1;
    manager_rw_address    = '0;
    manager_read_request  = '0;
    manager_write_request = '0;
    manager_write_data    = '0;
    manager_write_strobe  = '0;
    device_read_response  = '0;
    device_write_response = '0;
    device_read_data      = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};
    device_start_address  = {32'h8000_0000, 32'h8002_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
    device_region_size    = {32'h0010_0000, 32'h0001_0000, 32'h0000_0100, 32'h0000_1000, 32'h0001_0000};

    repeat (3) @(negedge clock);
    check("reset_busy",    64'(bus_busy), 64'd0);
    check("reset_dev_req", 64'({device_read_request, device_write_request}), 64'd0);
    check("reset_mgr_out", 64'({manager_read_response, manager_write_response, manager_access_fault}), 64'd0);
    check("reset_latch",   64'({device_rw_address, device_write_strobe}), 64'd0);
    check("reset_rdata",   manager_read_data, 64'd0);
    reset = 1'b0;

    // Round robin from pointer 0 with both managers requesting
    run_stream(2'b11, 4);
    check("rr_mgr0", 64'(s_mgr[0]), 64'd0);
    check("rr_mgr1", 64'(s_mgr[1]), 64'd1);
    check("rr_mgr2", 64'(s_mgr[2]), 64'd0);
    check("rr_mgr3", 64'(s_mgr[3]), 64'd1);
    check("rr_cyc0", 64'(s_cyc[0]), 64'd4);
    check("rr_cyc1", 64'(s_cyc[1]), 64'd8);
    check("rr_cyc3", 64'(s_cyc[3]), 64'd16);

    // M0 read of RAM, device answers one cycle after its request
    run_txn(0, 1, 0, 32'h0000_0010, 32'h0, 4'h0, 1);
    check("rd_cycle",   64'(r_cyc), 64'd5);
    check("rd_resp",    64'({r_rd, r_wr}), 64'b10);
    check("rd_fault",   64'(r_flt), 64'd0);
    check("rd_data",    64'(r_rdata), 64'hDEAD_BEEF);
    check("rd_other",   64'(r_rdall[63:32]), 64'd0);
    check("rd_devreq",  64'({r_dev_wr, r_dev_rd}), 64'b00000_00001);
    check("rd_acc",     64'(r_acc), 64'd2);
    check("rd_addr",    64'(r_addr), 64'h0000_0010);
    check("rd_pulse",   64'(r_after), 64'd0);

    // Served manager is held off for one IDLE cycle
    run_stream(2'b01, 2);
    check("mask_cyc0", 64'(s_cyc[0]), 64'd4);
    check("mask_cyc1", 64'(s_cyc[1]), 64'd9);

    // M1 write to an unmapped address
    run_txn(1, 0, 1, 32'h9000_0000, 32'h1234_5678, 4'hF, 0);
    check("miss_cycle",  64'(r_cyc), 64'd3);
    check("miss_resp",   64'({r_rd, r_wr}), 64'b01);
    check("miss_fault",  64'(r_flt), 64'd1);
    check("miss_devreq", 64'({r_dev_wr, r_dev_rd}), 64'd0);

    // Read and write together: write wins; d3 beats overlapping d4
    run_txn(0, 1, 1, 32'h8002_0004, 32'hCAFE_F00D, 4'b0110, 2);
    check("rw_cycle",  64'(r_cyc), 64'd6);
    check("rw_resp",   64'({r_rd, r_wr}), 64'b01);
    check("rw_devreq", 64'({r_dev_wr, r_dev_rd}), 64'b01000_00000);
    check("rw_fault",  64'(r_flt), 64'd0);
    check("rw_addr",   64'(r_addr), 64'h8002_0004);
    check("rw_wdata",  64'(r_wdata), 64'hCAFE_F00D);
    check("rw_strb",   64'(r_strb), 64'b0110);

    // Region boundaries
    run_txn(1, 1, 0, 32'h800F_FFFC, 32'h0, 4'h0, 0);
    check("top_cycle",  64'(r_cyc), 64'd4);
    check("top_devreq", 64'(r_dev_rd), 64'b10000);
    check("top_data",   64'(r_rdata), 64'h4444_4444);
    check("top_other",  64'(r_rdall[31:0]), 64'd0);
    run_txn(1, 1, 0, 32'h8010_0000, 32'h0, 4'h0, 0);
    check("past_cycle", 64'(r_cyc), 64'd3);
    check("past_fault", 64'({r_rd, r_flt}), 64'b11);
    check("past_data",  64'(r_rdata), 64'd0);
    run_txn(0, 1, 0, 32'h8001_FFFC, 32'h0, 4'h0, 0);
    check("below_d3", 64'(r_dev_rd), 64'b10000);
    run_txn(0, 1, 0, 32'h8002_FFFC, 32'h0, 4'h0, 0);
    check("end_d3", 64'(r_dev_rd), 64'b01000);

    // Reset during ACCESS after an M0 grant moved the pointer to 1
    @(negedge clock);
    manager_rw_address[31:0] = 32'h1000_0000;
    manager_read_request     = 2'b01;
    for (int i = 0; i < 20 && device_read_request == '0; i++) @(negedge clock);
    check("rst_acc_req", 64'(device_read_request), 64'b00010);
    reset = 1'b1;
    manager_read_request = '0;
    @(negedge clock);
    check("rst_dev_req", 64'({device_read_request, device_write_request}), 64'd0);
    check("rst_busy",    64'(bus_busy), 64'd0);
    check("rst_mgr_out", 64'({manager_read_response, manager_write_response, manager_access_fault}), 64'd0);
    reset = 1'b0;
    run_stream(2'b11, 1);
    check("rst_next_mgr", 64'(s_mgr[0]), 64'd0);
    check("rst_next_cyc", 64'(s_cyc[0]), 64'd4);

`ifdef RVX_BUS_TIMEOUT_EN
    // Mute device 2: request held TMO cycles, then a faulted read
    run_txn(0, 1, 0, 32'h2000_0000, 32'h0, 4'h0, 1000);
    check("tmo_cycle", 64'(r_cyc), 64'd11);
    check("tmo_acc",   64'(r_acc), 64'd8);
    check("tmo_fault", 64'({r_rd, r_flt}), 64'b11);
    check("tmo_data",  64'(r_rdata), 64'd0);
    // Response in the final allowed cycle wins over the timeout
    run_txn(0, 1, 0, 32'h2000_0004, 32'h0, 4'h0, 7);
    check("late_cycle", 64'(r_cyc), 64'd11);
    check("late_fault", 64'({r_rd, r_flt}), 64'b10);
    check("late_data",  64'(r_rdata), 64'h2222_2222);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
